// File: rtl/ram_bist_pkg.sv
// Shared definitions for the March C- RAM BIST: FSM states, element codes,
// data backgrounds and the per-element operation lookup.
package ram_bist_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_E0,
    ST_E1,
    ST_E2,
    ST_E3,
    ST_E4,
    ST_E5,
    ST_DRAIN,
    ST_DONE
  } state_t;

  localparam logic [2:0] EL_E0 = 3'd0;
  localparam logic [2:0] EL_E1 = 3'd1;
  localparam logic [2:0] EL_E2 = 3'd2;
  localparam logic [2:0] EL_E3 = 3'd3;
  localparam logic [2:0] EL_E4 = 3'd4;
  localparam logic [2:0] EL_E5 = 3'd5;

  localparam logic [15:0] BG0 = 16'h0000;
  localparam logic [15:0] BG1 = 16'hFFFF;

  // rd_only applies to single-op elements; two-op elements always read then write.
  typedef struct packed {
    logic down;
    logic two_op;
    logic rd_only;
    logic rd_bg;
    logic wr_bg;
  } elem_info_t;

  function automatic elem_info_t elem_info(input logic [2:0] el);
    elem_info_t info;
    info = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    case (el)
      EL_E1:   info = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
      EL_E2:   info = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
      EL_E3:   info = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1};
      EL_E4:   info = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
      EL_E5:   info = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      default: info = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    endcase
    return info;
  endfunction

  function automatic logic elem_down(input logic [2:0] el);
    return (el == EL_E3) || (el == EL_E4);
  endfunction

  function automatic logic [2:0] state_elem(input state_t s);
    logic [2:0] el;
    case (s)
      ST_E1:   el = EL_E1;
      ST_E2:   el = EL_E2;
      ST_E3:   el = EL_E3;
      ST_E4:   el = EL_E4;
      ST_E5:   el = EL_E5;
      default: el = EL_E0;
    endcase
    return el;
  endfunction

  function automatic state_t next_elem_state(input state_t s);
    state_t n;
    case (s)
      ST_E0:   n = ST_E1;
      ST_E1:   n = ST_E2;
      ST_E2:   n = ST_E3;
      ST_E3:   n = ST_E4;
      ST_E4:   n = ST_E5;
      default: n = ST_DRAIN;
    endcase
    return n;
  endfunction

  function automatic logic [15:0] bg_word(input logic b);
    return b ? BG1 : BG0;
  endfunction

endpackage

// File: rtl/ram_bist_addr_gen.sv
// Word-address sequencer for the March elements: up/down counter with start-address
// load, read/write phase toggle for two-op elements, and end-of-element flag.
module ram_bist_addr_gen #(
  parameter int AW = 7,
  parameter int N  = 128
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_load,
  input  logic          i_load_down,
  input  logic          i_step,
  input  logic          i_two_op,
  input  logic          i_down,
  output logic [AW-1:0] o_addr,
  output logic          o_phase,
  output logic          o_last
);
  localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);

  logic [AW-1:0] r_addr;
  logic          r_phase;
  logic          w_term;

  // A load always wins, so stepping past the terminal address never wraps.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_addr  <= '0;
      r_phase <= 1'b0;
    end else if (i_load) begin
      r_addr  <= i_load_down ? LAST_ADDR : '0;
      r_phase <= 1'b0;
    end else if (i_step) begin
      if (i_two_op && !r_phase) begin
        r_phase <= 1'b1;
      end else begin
        r_phase <= 1'b0;
        r_addr  <= i_down ? (r_addr - AW'(1)) : (r_addr + AW'(1));
      end
    end
  end

  assign w_term  = i_down ? (r_addr == '0) : (r_addr == LAST_ADDR);
  assign o_addr  = r_addr;
  assign o_phase = r_phase;
  assign o_last  = w_term && (!i_two_op || r_phase);

endmodule

// File: rtl/ram_bist_ctrl.sv
// March C- BIST controller and RAM port multiplexer. Functional traffic passes
// straight through unless a test run owns the port.
module ram_bist_ctrl
  import ram_bist_pkg::*;
#(
  parameter int ADDR_MSB = 6,
  parameter int MEM_SIZE = 256
) (
  input  logic              mclk,
  input  logic              puc_rst,
  input  logic              bist_start,
  output logic              bist_busy,
  output logic              bist_done,
  output logic              bist_fail,
  output logic [ADDR_MSB:0] bist_fail_addr,
  output logic [2:0]        bist_fail_elem,
  input  logic [ADDR_MSB:0] func_addr,
  input  logic              func_cen,
  input  logic [15:0]       func_din,
  input  logic [1:0]        func_wen,
  output logic [ADDR_MSB:0] ram_addr,
  output logic              ram_cen,
  output logic [15:0]       ram_din,
  output logic [1:0]        ram_wen,
  input  logic [15:0]       ram_dout
);
  localparam int N  = MEM_SIZE / 2;
  localparam int AW = ADDR_MSB + 1;

  state_t     r_state;
  state_t     w_state_nxt;
  logic       r_busy;
  logic       w_busy_nxt;
  logic       w_start;
  logic       w_in_elem;
  logic [2:0] w_elem;
  elem_info_t w_info;
  logic       w_is_read;

  logic          w_load;
  logic          w_load_down;
  logic          w_step;
  logic [AW-1:0] w_addr;
  logic          w_phase;
  logic          w_last;

  logic          r_cmp_vld;
  logic [15:0]   r_cmp_exp;
  logic [AW-1:0] r_cmp_addr;
  logic [2:0]    r_cmp_elem;
  logic          w_mismatch;

  logic          r_done;
  logic          r_fail;
  logic [AW-1:0] r_fail_addr;
  logic [2:0]    r_fail_elem;

  assign w_start   = bist_start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_in_elem = (r_state != ST_IDLE) && (r_state != ST_DONE) && (r_state != ST_DRAIN);
  assign w_elem    = state_elem(r_state);
  assign w_info    = elem_info(w_elem);
  assign w_is_read = w_in_elem && (w_info.two_op ? !w_phase : w_info.rd_only);

  // r_busy tracks r_state so the DUT outputs stay clean; no compare outside a run.
  assign w_mismatch = r_busy && r_cmp_vld && (ram_dout != r_cmp_exp);

  ram_bist_addr_gen #(
    .AW (AW),
    .N  (N)
  ) u_addr_gen (
    .i_clk       (mclk),
    .i_rst       (puc_rst),
    .i_load      (w_load),
    .i_load_down (w_load_down),
    .i_step      (w_step),
    .i_two_op    (w_info.two_op),
    .i_down      (w_info.down),
    .o_addr      (w_addr),
    .o_phase     (w_phase),
    .o_last      (w_last)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    w_load_down = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (bist_start) begin
          w_state_nxt = ST_E0;
          w_load      = 1'b1;
        end
      end
      ST_DRAIN: w_state_nxt = ST_DONE;
      default: begin
        if (w_mismatch) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_step = 1'b1;
          if (w_last) begin
            w_state_nxt = next_elem_state(r_state);
            w_load      = 1'b1;
            w_load_down = elem_down(state_elem(w_state_nxt));
          end
        end
      end
    endcase
  end

  assign w_busy_nxt = (w_state_nxt != ST_IDLE) && (w_state_nxt != ST_DONE);

  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

  // Each read is checked one cycle later, when the RAM presents its data.
  always_ff @(posedge mclk) begin
    if (puc_rst) begin
      r_cmp_vld  <= 1'b0;
      r_cmp_exp  <= '0;
      r_cmp_addr <= '0;
      r_cmp_elem <= '0;
    end else begin
      r_cmp_vld  <= w_is_read;
      r_cmp_exp  <= bg_word(w_info.rd_bg);
      r_cmp_addr <= w_addr;
      r_cmp_elem <= w_elem;
    end
  end

  always_ff @(posedge mclk) begin
    if (puc_rst || w_start) begin
      r_done      <= 1'b0;
      r_fail      <= 1'b0;
      r_fail_addr <= '0;
      r_fail_elem <= '0;
    end else if (w_mismatch) begin
      r_done      <= 1'b1;
      r_fail      <= 1'b1;
      r_fail_addr <= r_cmp_addr;
      r_fail_elem <= r_cmp_elem;
    end else if (r_state == ST_DRAIN) begin
      r_done <= 1'b1;
    end
  end

  assign bist_busy      = r_busy;
  assign bist_done      = r_done;
  assign bist_fail      = r_fail;
  assign bist_fail_addr = r_fail_addr;
  assign bist_fail_elem = r_fail_elem;

  assign ram_addr = r_busy ? w_addr : func_addr;
  assign ram_cen  = r_busy ? !w_in_elem : func_cen;
  assign ram_din  = r_busy ? bg_word(w_info.wr_bg) : func_din;
  assign ram_wen  = r_busy ? ((w_in_elem && !w_is_read) ? 2'b00 : 2'b11) : func_wen;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Self-checking bench for ram_bist_ctrl: N=128 and N=4 instances, each with a
// behavioural RAM (optional stuck-at / coupling fault) and an op-list March C- reference.
module tb_ram_bist_ctrl;
  localparam int N  = 128;
  localparam int TW = 26;

  logic mclk = 1'b0;
  logic puc_rst;
  always #5 mclk = ~mclk;

  int total = 0;
  int bad   = 0;

  logic start_req;
  logic sel8;

  logic        bist_start, bist_busy, bist_done, bist_fail;
  logic [6:0]  bist_fail_addr;
  logic [2:0]  bist_fail_elem;
  logic [6:0]  func_addr;
  logic        func_cen;
  logic [15:0] func_din;
  logic [1:0]  func_wen;
  logic [6:0]  ram_addr;
  logic        ram_cen;
  logic [15:0] ram_din;
  logic [15:0] ram_dout;
  logic [1:0]  ram_wen;

  logic        s_start, s_busy, s_done, s_fail;
  logic [1:0]  s_fail_addr;
  logic [2:0]  s_fail_elem;
  logic [1:0]  s_func_addr;
  logic [1:0]  s_ram_addr;
  logic        s_ram_cen;
  logic [15:0] s_ram_din;
  logic [15:0] s_ram_dout;
  logic [1:0]  s_ram_wen;

  assign bist_start  = start_req & ~sel8;
  assign s_start     = start_req & sel8;
  assign s_func_addr = func_addr[1:0];

  ram_bist_ctrl #(.ADDR_MSB(6), .MEM_SIZE(256)) u_dut (
    .mclk(mclk), .puc_rst(puc_rst), .bist_start(bist_start), .bist_busy(bist_busy),
    .bist_done(bist_done), .bist_fail(bist_fail), .bist_fail_addr(bist_fail_addr),
    .bist_fail_elem(bist_fail_elem), .func_addr(func_addr), .func_cen(func_cen),
    .func_din(func_din), .func_wen(func_wen), .ram_addr(ram_addr), .ram_cen(ram_cen),
    .ram_din(ram_din), .ram_wen(ram_wen), .ram_dout(ram_dout)
  );

  ram_bist_ctrl #(.ADDR_MSB(1), .MEM_SIZE(8)) u_dut8 (
    .mclk(mclk), .puc_rst(puc_rst), .bist_start(s_start), .bist_busy(s_busy),
    .bist_done(s_done), .bist_fail(s_fail), .bist_fail_addr(s_fail_addr),
    .bist_fail_elem(s_fail_elem), .func_addr(s_func_addr), .func_cen(func_cen),
    .func_din(func_din), .func_wen(func_wen), .ram_addr(s_ram_addr), .ram_cen(s_ram_cen),
    .ram_din(s_ram_din), .ram_wen(s_ram_wen), .ram_dout(s_ram_dout)
  );

  // Observation view of whichever instance is under test
  logic        o_busy, o_done, o_fail, o_cen;
  logic [6:0]  o_fail_addr, o_addr;
  logic [2:0]  o_fail_elem;
  logic [1:0]  o_wen;
  logic [15:0] o_din;
  assign o_busy      = sel8 ? s_busy : bist_busy;
  assign o_done      = sel8 ? s_done : bist_done;
  assign o_fail      = sel8 ? s_fail : bist_fail;
  assign o_fail_addr = sel8 ? {5'b0, s_fail_addr} : bist_fail_addr;
  assign o_fail_elem = sel8 ? s_fail_elem : bist_fail_elem;
  assign o_addr      = sel8 ? {5'b0, s_ram_addr} : ram_addr;
  assign o_cen       = sel8 ? s_ram_cen : ram_cen;
  assign o_wen       = sel8 ? s_ram_wen : ram_wen;
  assign o_din       = sel8 ? s_ram_din : ram_din;

  // Fault config: 0 none, 1 stuck-at (f_addr, f_bit, f_val), 2 coupling (write of non-zero to f_agg sets f_vic bit 0)
  int   f_kind = 0, f_addr = 0, f_bit = 0, f_agg = 0, f_vic = 0;
  logic f_val = 1'b0;

  function automatic logic [15:0] flt_read(input logic [15:0] v, input int a);
    logic [15:0] r;
    r = v;
    if (f_kind == 1 && a == f_addr) r[f_bit] = f_val;
    return r;
  endfunction

  logic [15:0] mem  [0:N-1];
  logic [15:0] mem8 [0:3];

  always @(posedge mclk) begin
    if (!ram_cen) begin
      ram_dout <= flt_read(mem[ram_addr], int'(ram_addr));
      if (!ram_wen[0]) mem[ram_addr][7:0]  <= ram_din[7:0];
      if (!ram_wen[1]) mem[ram_addr][15:8] <= ram_din[15:8];
      if (f_kind == 2 && ram_wen != 2'b11 && int'(ram_addr) == f_agg && ram_din != 16'h0)
        mem[f_vic][0] <= 1'b1;
    end
  end

  always @(posedge mclk) begin
    if (!s_ram_cen) begin
      s_ram_dout <= mem8[s_ram_addr];
      if (!s_ram_wen[0]) mem8[s_ram_addr][7:0]  <= s_ram_din[7:0];
      if (!s_ram_wen[1]) mem8[s_ram_addr][15:8] <= s_ram_din[15:8];
    end
  end

  // Reference: expected RAM-port op per busy cycle, {cen, wen, din, addr}
  logic [TW-1:0] exp_q[$];
  logic [15:0]   ref_mem [0:N-1];
  int            exp_busy, exp_faddr, exp_felem;
  logic          exp_fail;

  function automatic logic [TW-1:0] pack_op(input logic cen, input logic [1:0] wen,
                                             input logic [15:0] din, input int a);
    logic [6:0] a7;
    a7 = a[6:0];
    return {cen, wen, din, a7};
  endfunction

  function automatic logic [TW-1:0] obs_op();
    if (o_cen) return pack_op(1'b1, 2'b11, 16'h0, 0);
    return pack_op(1'b0, o_wen, (o_wen == 2'b11) ? 16'h0 : o_din, int'(o_addr));
  endfunction

  task automatic build_ref(input int n);
    logic [1:0]  ops [6][2];
    int          nops [6];
    int          fi;
    logic [15:0] bg, got;
    // op code {is_read, value}: W0=00 W1=01 R0=10 R1=11
    ops  = '{'{2'b00, 2'b00}, '{2'b10, 2'b01}, '{2'b11, 2'b00},
             '{2'b10, 2'b01}, '{2'b11, 2'b00}, '{2'b10, 2'b10}};
    nops = '{1, 2, 2, 2, 2, 1};
    exp_q.delete();
    fi = -1; exp_faddr = 0; exp_felem = 0;
    for (int i = 0; i < N; i++) ref_mem[i] = 16'($urandom);
    for (int e = 0; e < 6; e++) begin
      for (int k = 0; k < n; k++) begin
        int a;
        a = (e == 3 || e == 4) ? n - 1 - k : k;
        for (int j = 0; j < nops[e]; j++) begin
          bg = ops[e][j][0] ? 16'hFFFF : 16'h0000;
          if (ops[e][j][1]) begin
            exp_q.push_back(pack_op(1'b0, 2'b11, 16'h0, a));
            got = flt_read(ref_mem[a], a);
            if (got != bg && fi < 0) begin
              fi = exp_q.size() - 1; exp_faddr = a; exp_felem = e;
            end
          end else begin
            exp_q.push_back(pack_op(1'b0, 2'b00, bg, a));
            ref_mem[a] = bg;
            if (f_kind == 2 && a == f_agg && bg != 16'h0) ref_mem[f_vic][0] = 1'b1;
          end
        end
      end
    end
    exp_q.push_back(pack_op(1'b1, 2'b11, 16'h0, 0));
    exp_fail = (fi >= 0);
    if (fi >= 0) while (exp_q.size() > fi + 2) void'(exp_q.pop_back());
    exp_busy = exp_q.size();
  endtask

  task automatic run_bist(input string name, input int n, input bit hold);
    int cyc, seq_err, first_c;
    logic [TW-1:0] e, o, first_o, first_e;
    build_ref(n);
    func_cen = 1'b1;
    @(negedge mclk); start_req = 1'b1;
    @(negedge mclk); if (!hold) start_req = 1'b0;
    total++;
    if (o_busy !== 1'b1) begin
      bad++; $display("FAIL %s busy_after_start: got %b want 1", name, o_busy);
    end
    cyc = 0; seq_err = 0; first_c = -1; first_o = '0; first_e = '0;
    while (o_busy === 1'b1 && cyc < 20 * n + 10) begin
      o = obs_op();
      if (exp_q.size() == 0) e = '1;
      else e = exp_q.pop_front();
      if (o !== e) begin
        if (seq_err == 0) begin first_c = cyc; first_o = o; first_e = e; end
        seq_err++;
      end
      func_addr = 7'($urandom); func_cen = 1'($urandom);
      func_din  = 16'($urandom); func_wen = 2'($urandom);
      cyc++;
      @(negedge mclk);
    end
    func_cen = 1'b1;
    total++;
    if (seq_err != 0 || exp_q.size() != 0) begin
      bad++;
      $display("FAIL %s port_seq: %0d bad cycles, first at %0d got %h want %h, %0d ops unissued",
               name, seq_err, first_c, first_o, first_e, exp_q.size());
    end
    total++;
    if (cyc != exp_busy) begin
      bad++; $display("FAIL %s busy_cycles: got %0d want %0d", name, cyc, exp_busy);
    end
    total++;
    if (o_done !== 1'b1) begin
      bad++; $display("FAIL %s done: got %b want 1", name, o_done);
    end
    total++;
    if (o_fail !== exp_fail) begin
      bad++; $display("FAIL %s fail_flag: got %b want %b", name, o_fail, exp_fail);
    end
    total++;
    if (o_fail_addr !== 7'(exp_faddr) || o_fail_elem !== 3'(exp_felem)) begin
      bad++; $display("FAIL %s fail_loc: got addr %0d elem %0d want addr %0d elem %0d",
                      name, o_fail_addr, o_fail_elem, exp_faddr, exp_felem);
    end
  endtask

  task automatic test_reset;
    puc_rst = 1'b1; start_req = 1'b0; sel8 = 1'b0;
    func_addr = 7'h2A; func_cen = 1'b1; func_din = 16'h1234; func_wen = 2'b01;
    repeat (3) @(negedge mclk);
    total++;
    if ({bist_busy, bist_done, bist_fail, bist_fail_addr, bist_fail_elem} !== 13'h0) begin
      bad++; $display("FAIL reset_outputs: got busy=%b done=%b fail=%b addr=%0d elem=%0d want all 0",
                      bist_busy, bist_done, bist_fail, bist_fail_addr, bist_fail_elem);
    end
    total++;
    if ({s_busy, s_done, s_fail, s_fail_addr, s_fail_elem} !== 8'h0) begin
      bad++; $display("FAIL reset_outputs_n4: got %b want 0", {s_busy, s_done, s_fail, s_fail_addr, s_fail_elem});
    end
    total++;
    if ({ram_addr, ram_cen, ram_din, ram_wen} !== {7'h2A, 1'b1, 16'h1234, 2'b01}) begin
      bad++; $display("FAIL reset_passthrough: got %h want %h", {ram_addr, ram_cen, ram_din, ram_wen},
                      {7'h2A, 1'b1, 16'h1234, 2'b01});
    end
    puc_rst = 1'b0;
    @(negedge mclk);
  endtask

  task automatic test_passthrough;
    logic [25:0] want;
    for (int i = 0; i < 6; i++) begin
      func_addr = 7'($urandom); func_cen = 1'($urandom);
      func_din  = 16'($urandom); func_wen = 2'($urandom);
      want = {func_addr, func_cen, func_din, func_wen};
      #1;
      total++;
      if ({ram_addr, ram_cen, ram_din, ram_wen} !== want) begin
        bad++; $display("FAIL passthrough_%0d: got %h want %h", i, {ram_addr, ram_cen, ram_din, ram_wen}, want);
      end
      @(negedge mclk);
    end
    func_addr = 7'd5; func_cen = 1'b0; func_wen = 2'b00; func_din = 16'hA5C3;
    @(negedge mclk);
    func_wen = 2'b11; func_din = 16'($urandom);
    @(negedge mclk);
    func_cen = 1'b1;
    total++;
    if (ram_dout !== 16'hA5C3) begin
      bad++; $display("FAIL func_write_read: got %h want a5c3", ram_dout);
    end
  endtask

  task automatic test_fault_free;
    f_kind = 0;
    run_bist("fault_free", N, 1'b0);
    test_passthrough();
  endtask

  task automatic test_stuck_at;
    f_kind = 1; f_addr = 17; f_bit = 3; f_val = 1'b1;
    run_bist("stuck17", N, 1'b0);
    total++;
    if (o_fail !== 1'b1 || o_fail_addr !== 7'd17 || o_fail_elem !== 3'd1) begin
      bad++; $display("FAIL stuck17_loc: got fail=%b addr=%0d elem=%0d want 1/17/1", o_fail, o_fail_addr, o_fail_elem);
    end
    repeat (4) @(negedge mclk);
    total++;
    if ({o_busy, o_done, o_fail} !== 3'b011 || o_fail_addr !== 7'd17) begin
      bad++; $display("FAIL stuck17_hold: got busy/done/fail=%b addr=%0d want 011/17", {o_busy, o_done, o_fail}, o_fail_addr);
    end
    for (int i = 0; i < 3; i++) begin
      f_addr = $urandom_range(0, N - 1); f_bit = $urandom_range(0, 15); f_val = 1'($urandom_range(0, 1));
      run_bist($sformatf("stuck_rand%0d", i), N, 1'b0);
    end
  endtask

  task automatic test_coupling;
    f_kind = 2; f_agg = 40; f_vic = 39;
    run_bist("couple40_39", N, 1'b0);
    total++;
    if (o_fail !== 1'b1 || o_fail_addr !== 7'd39 || o_fail_elem !== 3'd3) begin
      bad++; $display("FAIL couple_loc: got fail=%b addr=%0d elem=%0d want 1/39/3", o_fail, o_fail_addr, o_fail_elem);
    end
    for (int i = 0; i < 2; i++) begin
      f_agg = $urandom_range(0, N - 1);
      f_vic = (f_agg + $urandom_range(1, N - 1)) % N;
      run_bist($sformatf("couple_rand%0d", i), N, 1'b0);
    end
    f_kind = 0;
  endtask

  task automatic test_back_to_back;
    int cyc;
    f_kind = 0;
    run_bist("hold_start", N, 1'b1);
    @(negedge mclk);
    total++;
    if (o_busy !== 1'b1) begin
      bad++; $display("FAIL restart_after_done: got busy=%b want 1", o_busy);
    end
    start_req = 1'b0;
    cyc = 0;
    while (o_busy === 1'b1 && cyc < 20 * N) begin cyc++; @(negedge mclk); end
    total++;
    if (cyc != 10 * N + 1 || o_done !== 1'b1 || o_fail !== 1'b0) begin
      bad++; $display("FAIL restart_run: got %0d cycles done=%b fail=%b want %0d/1/0", cyc, o_done, o_fail, 10 * N + 1);
    end
  endtask

  task automatic test_reset_midrun;
    logic [6:0] fa;
    f_kind = 0;
    @(negedge mclk); start_req = 1'b1;
    @(negedge mclk); start_req = 1'b0;
    repeat (299) @(negedge mclk);
    fa = 7'($urandom);
    func_addr = fa; func_cen = 1'b1; puc_rst = 1'b1;
    @(negedge mclk);
    total++;
    if ({bist_busy, bist_done, bist_fail, bist_fail_addr, bist_fail_elem} !== 13'h0) begin
      bad++; $display("FAIL midrun_reset_flags: got busy=%b done=%b fail=%b want 0", bist_busy, bist_done, bist_fail);
    end
    total++;
    if (ram_addr !== fa || ram_cen !== 1'b1) begin
      bad++; $display("FAIL midrun_reset_mux: got addr=%h cen=%b want %h/1", ram_addr, ram_cen, fa);
    end
    puc_rst = 1'b0;
    run_bist("after_reset", N, 1'b0);
  endtask

  task automatic test_small;
    f_kind = 0; sel8 = 1'b1;
    run_bist("n4", 4, 1'b0);
    sel8 = 1'b0;
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < N; i++) mem[i] = 16'($urandom);
    for (int i = 0; i < 4; i++) mem8[i] = 16'($urandom);
    ram_dout = 16'h0; s_ram_dout = 16'h0;
    test_reset();
    test_fault_free();
    test_stuck_at();
    test_coupling();
    test_back_to_back();
    test_reset_midrun();
    test_small();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_bist_ctrl.md
# ram_bist_ctrl

March C- built-in self-test controller and port multiplexer placed directly upstream of the scalable `ram` model. In mission mode it passes the functional memory-backbone signals straight through to the RAM port. When a test is started, it takes over the RAM port and runs a full March C- pass over all `MEM_SIZE/2` words using the 0x0000/0xFFFF data backgrounds. It then reports pass/fail with the first failing address and element.

## Interface
Parameters:
- `ADDR_MSB`, 6: MSB of the RAM word address bus.
- `MEM_SIZE`, 256: memory size in bytes; the test covers words `0 .. MEM_SIZE/2-1`.

Ports:
- `mclk`  in  1  single clock for the block and the RAM (`ram_clk` is tied to `mclk`).
- `puc_rst`  in  1  reset; synchronous, active-high.
- `bist_start`  in  1  start request; sampled only in IDLE or DONE.
- `bist_busy`  out  1  high while the BIST owns the RAM port.
- `bist_done`  out  1  sticky completion flag.
- `bist_fail`  out  1  sticky mismatch flag; valid when `bist_done`=1.
- `bist_fail_addr`  out  ADDR_MSB+1  word address of the first mismatch.
- `bist_fail_elem`  out  3  March element (1..5) of the first mismatch.
- `func_addr`  in  ADDR_MSB+1  functional RAM address.
- `func_cen`  in  1  functional chip enable, active low.
- `func_din`  in  16  functional write data.
- `func_wen`  in  2  functional byte write enables, active low.
- `ram_addr`  out  ADDR_MSB+1  to RAM.
- `ram_cen`  out  1  to RAM.
- `ram_din`  out  16  to RAM.
- `ram_wen`  out  2  to RAM.
- `ram_dout`  in  16  from RAM; reflects the address registered at the previous enabled edge.

## Operation
- Mux:
  - When `bist_busy`=0, `ram_*` = `func_*`, combinationally.
  - When `bist_busy`=1, `ram_*` are driven by the BIST and `func_*` are ignored.
- Elements, with N = MEM_SIZE/2 and addresses wrapping nowhere (terminal count ends the element):
  - E0 ⇑ w0
  - E1 ⇑ (r0, w1)
  - E2 ⇑ (r1, w0)
  - E3 ⇓ (r0, w1)
  - E4 ⇓ (r1, w0)
  - E5 ⇑ r0
  - "0" = 16'h0000 and "1" = 16'hFFFF. Writes use `ram_wen`=2'b00. Reads use `ram_wen`=2'b11 and `ram_cen`=0.
- States: IDLE, E0..E5, DRAIN, DONE.
  - IDLE/DONE + `bist_start` → E0 with address 0; `done`, `fail`, `fail_addr` and `fail_elem` are cleared.
  - Each element advances to the next when its terminal address (N-1 for ⇑, 0 for ⇓) completes. The next element's start address is loaded in the same cycle.
  - E5 at address N-1 → DRAIN, one cycle with `ram_cen`=1, for the final compare.
  - DRAIN → DONE.
- Compare:
  - Read data is checked in the cycle after the read, against the expected value for that read.
  - In E1–E4 the compare overlaps the write cycle of the same address.
  - On the first mismatch, set `fail`, capture the address and element, and abort to DONE on the next edge. No further RAM accesses are issued.
- `bist_start` while busy is ignored. DONE holds its flags until the next start or reset.
- Reset, including mid-test: state → IDLE, all outputs 0, and the RAM port returns to functional pass-through on the next cycle. RAM contents are undefined afterwards.

## Timing
- `bist_start` high at edge k → `bist_busy`=1 from cycle k+1.
- Passing run: `bist_busy` stays high for exactly 10N+1 cycles (E0 N, E1–E4 2N each, E5 N, DRAIN 1). `bist_done`=1 in the first cycle after.
- Per address in E1–E4: cycle t is a read (addr a); cycle t+1 writes addr a and compares `ram_dout`.
- Fail abort: a mismatch is detected in cycle c. Then `bist_busy`=0, `bist_done`=1 and `bist_fail`=1 are visible in cycle c+1.
- Mux switching is combinational on registered `bist_busy`; there are no glitches within a cycle.
- Reset values: `bist_busy`=0, `bist_done`=0, `bist_fail`=0, `bist_fail_addr`=0, `bist_fail_elem`=0.

## Structure
- Shared package `ram_bist_pkg`:
  - state encodings (IDLE, E0..E5, DRAIN, DONE);
  - element codes;
  - background constants BG0=16'h0000, BG1=16'hFFFF;
  - the per-element direction and read/write-value lookup.
- Sub-module `ram_bist_addr_gen`:
  - up/down word-address counter with load-to-0 and load-to-(N-1);
  - terminal-count flag;
  - phase toggle (read/write) for two-op elements.
- The top level holds the FSM, the compare/capture registers and the port mux.

## Test plan
- Fault-free RAM, MEM_SIZE=256 (N=128): pulse start → busy for 1281 cycles, done=1, fail=0, then func pass-through verified by a write/read of 16'hA5C3 at addr 5.
- Stuck-at-1 bit 3 injected at word 17 → fail=1, fail_addr=17, fail_elem=1, busy drops one cycle after the E1 read of addr 17.
- Coupling fault (writing 1 to word 40 flips word 39 bit 0 to 1) → fail=1, fail_addr=39, fail_elem=3 (first detection on the ⇓ r0 of word 39).
- Reset asserted at cycle 300 of a run → next cycle busy=0, done=0, fail=0; `ram_addr` equals `func_addr`. Restart passes in 1281 cycles.
- `bist_start` held high throughout a run → no restart while busy; a restart occurs one cycle after DONE is reached.
- MEM_SIZE=8 (N=4) edge case → busy for exactly 41 cycles, and the address sequence matches the ⇑/⇓ order, including the 3→0 and 0→3 element boundaries.
